// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind a posted write buffer with fixed read latency.
// Optional feature macro: DMEM_FWD_EN (loads forward from pending buffered stores).
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LAT      = 2,
  parameter int WBUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wd,
  output logic [31:0] dmem_rd,
  output logic        dmem_rvalid,
  output logic        dmem_stall,
  output logic        wbuf_empty
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int NW = $clog2(WBUF_DEPTH + 1);
  localparam int CW = $clog2(RD_LAT + 1);

`ifdef DMEM_FWD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, DRAIN = 2'd2} state_t;
`endif

  logic [31:0]   mem      [DEPTH_WORDS];
  logic [AW-1:0] buf_addr [WBUF_DEPTH];
  logic [31:0]   buf_data [WBUF_DEPTH];

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [NW-1:0] count;
  logic [CW-1:0] lat_cnt;
  logic [31:0]   rd_data_q;

  logic [AW-1:0] idx;
  logic          full;
  logic          store_acc;
  logic          load_issue;
  logic          drain;
  logic [31:0]   read_word;
  logic          unused_addr_bits;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(WBUF_DEPTH - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = p + 1'b1;
    end
  endfunction

  assign idx              = dmem_addr[AW+1:2];
  assign unused_addr_bits = ^{dmem_addr[31:AW+2], dmem_addr[1:0]};
  assign full             = (count == NW'(WBUF_DEPTH));
  assign store_acc        = (state == IDLE) && dmem_req && dmem_we && !full;
`ifdef DMEM_FWD_EN
  assign load_issue       = (state == IDLE) && dmem_req && !dmem_we && !dmem_rvalid;
`else
  assign load_issue       = ((state == IDLE) || (state == DRAIN)) && dmem_req && !dmem_we &&
                            !dmem_rvalid && (count == NW'(0));
`endif
  // A read issue owns the RAM port; reset discards whatever is still buffered.
  assign drain            = (count != NW'(0)) && !load_issue && !reset;
  assign dmem_stall       = dmem_req && !(store_acc || dmem_rvalid);
  assign wbuf_empty       = (count == NW'(0));

`ifdef DMEM_FWD_EN
  logic [PW-1:0] fwd_slot;

  // Walk entries oldest to youngest so the youngest matching store wins.
  always_comb begin
    read_word = mem[idx];
    fwd_slot  = rd_ptr;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      fwd_slot = PW'((int'(rd_ptr) + i) % WBUF_DEPTH);
      if ((i < int'(count)) && (buf_addr[fwd_slot] == idx)) begin
        read_word = buf_data[fwd_slot];
      end else begin
        read_word = read_word;
      end
    end
  end
`else
  assign read_word = mem[idx];
`endif

  // RAM and buffer storage; contents are never reset.
  always_ff @(posedge clk) begin
    if (store_acc) begin
      buf_addr[wr_ptr] <= idx;
      buf_data[wr_ptr] <= dmem_wd;
    end
    if (drain) begin
      mem[buf_addr[rd_ptr]] <= buf_data[rd_ptr];
    end
  end

  // Control FSM, buffer pointers and registered load response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      lat_cnt     <= '0;
      rd_data_q   <= 32'd0;
      dmem_rd     <= 32'd0;
      dmem_rvalid <= 1'b0;
    end else begin
      dmem_rvalid <= 1'b0;
      if (store_acc) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (drain) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      count <= count + NW'(store_acc) - NW'(drain);

      if (load_issue) begin
        if (RD_LAT == 1) begin
          dmem_rvalid <= 1'b1;
          dmem_rd     <= read_word;
          state       <= IDLE;
        end else begin
          rd_data_q <= read_word;
          lat_cnt   <= CW'(1);
          state     <= RD_WAIT;
        end
      end else begin
        case (state)
          IDLE: begin
`ifndef DMEM_FWD_EN
            if (dmem_req && !dmem_we && !dmem_rvalid && (count != NW'(0))) begin
              state <= DRAIN;
            end
`endif
          end
          RD_WAIT: begin
            if (lat_cnt == CW'(RD_LAT - 1)) begin
              dmem_rvalid <= 1'b1;
              dmem_rd     <= rd_data_q;
              state       <= IDLE;
            end else begin
              lat_cnt <= lat_cnt + CW'(1);
            end
          end
`ifndef DMEM_FWD_EN
          DRAIN: begin
            state <= DRAIN;
          end
`endif
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus random traffic against a
// flat-memory reference with a pending-write counter.
module tb_dmem_responder;
  localparam int DEPTH_WORDS = 256;
  localparam int RD_LAT      = 2;
  localparam int WBUF_DEPTH  = 2;
`ifdef DMEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wd;
  logic [31:0] dmem_rd;
  logic        dmem_rvalid;
  logic        dmem_stall;
  logic        wbuf_empty;

  dmem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .RD_LAT(RD_LAT), .WBUF_DEPTH(WBUF_DEPTH)) dut (
    .clk(clk), .reset(reset), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wd(dmem_wd), .dmem_rd(dmem_rd),
    .dmem_rvalid(dmem_rvalid), .dmem_stall(dmem_stall), .wbuf_empty(wbuf_empty)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          pend   = 0;
  logic [31:0] ref_mem [DEPTH_WORDS];
  bit          written [DEPTH_WORDS];
  logic [31:0] last_rd;
  bit          rd_known;

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge; the buffer drains one entry per edge unless a read issues.
  task automatic step(input bit push, input bit issue);
    bit drained;
    drained = (pend > 0) && !issue;
    @(posedge clk);
    pend = pend + int'(push) - int'(drained);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      dmem_req  = 1'b0;
      dmem_we   = 1'($urandom_range(0, 1));
      dmem_addr = $urandom;
      dmem_wd   = $urandom;
      @(negedge clk);
      chk("idle_stall", 32'(dmem_stall), 32'd0);
      chk("idle_rvalid", 32'(dmem_rvalid), 32'd0);
      chk("idle_empty", 32'(wbuf_empty), 32'(pend == 0));
      if (rd_known) chk("rd_hold", dmem_rd, last_rd);
      step(1'b0, 1'b0);
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    dmem_req  = 1'b1;
    dmem_we   = 1'b1;
    dmem_addr = a;
    dmem_wd   = d;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("st_stall", 32'(dmem_stall), 32'(pend >= WBUF_DEPTH));
      chk("st_rvalid", 32'(dmem_rvalid), 32'd0);
      chk("st_empty", 32'(wbuf_empty), 32'(pend == 0));
      if (pend < WBUF_DEPTH) begin
        step(1'b1, 1'b0);
        break;
      end
      step(1'b0, 1'b0);
    end
    ref_mem[widx(a)] = d;
    written[widx(a)] = 1'b1;
  endtask

  // Loads see program order; without forwarding they wait for the buffer to empty first.
  task automatic ld(input logic [31:0] a, input bit check_data);
    logic [31:0] exp;
    exp       = ref_mem[widx(a)];
    dmem_req  = 1'b1;
    dmem_we   = 1'b0;
    dmem_addr = a;
    for (int k = 0; k < 16 && !FWD && pend > 0; k++) begin
      @(negedge clk);
      chk("ld_drain_stall", 32'(dmem_stall), 32'd1);
      chk("ld_drain_rvalid", 32'(dmem_rvalid), 32'd0);
      step(1'b0, 1'b0);
    end
    @(negedge clk);
    chk("ld_issue_stall", 32'(dmem_stall), 32'd1);
    chk("ld_issue_rvalid", 32'(dmem_rvalid), 32'd0);
    chk("ld_issue_empty", 32'(wbuf_empty), 32'(pend == 0));
    step(1'b0, 1'b1);
    for (int k = 1; k < RD_LAT; k++) begin
      @(negedge clk);
      chk("ld_wait_stall", 32'(dmem_stall), 32'd1);
      chk("ld_wait_rvalid", 32'(dmem_rvalid), 32'd0);
      step(1'b0, 1'b0);
    end
    @(negedge clk);
    chk("ld_rvalid", 32'(dmem_rvalid), 32'd1);
    chk("ld_done_stall", 32'(dmem_stall), 32'd0);
    if (check_data) chk("ld_data", dmem_rd, exp);
    last_rd  = exp;
    rd_known = check_data;
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] old;
    logic [31:0] a;
    logic [31:0] d;
    int          w;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    dmem_addr = 32'd0;
    dmem_wd   = 32'd0;
    reset     = 1'b1;
    for (int i = 0; i < DEPTH_WORDS; i++) written[i] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pend  = 0;
    @(negedge clk);
    chk("rst_rd", dmem_rd, 32'd0);
    chk("rst_rvalid", 32'(dmem_rvalid), 32'd0);
    chk("rst_stall", 32'(dmem_stall), 32'd0);
    chk("rst_empty", 32'(wbuf_empty), 32'd1);
    last_rd  = 32'd0;
    rd_known = 1'b1;
    step(1'b0, 1'b0);

    // Load latency from reset
    ld(32'h10, 1'b0);
    idle(1);

    // Store, let it drain, read back
    st(32'h40, 32'hDEADBEEF);
    idle(3);
    ld(32'h40, 1'b1);

    // Back-to-back stores then read back each
    st(32'h0, $urandom);
    st(32'h4, $urandom);
    st(32'h8, $urandom);
    ld(32'h0, 1'b1);
    ld(32'h4, 1'b1);
    ld(32'h8, 1'b1);

    // Same-address stores followed at once by a load
    st(32'h20, 32'h1);
    st(32'h20, 32'h2);
    ld(32'h20, 1'b1);
    idle(1);

    // Address aliasing above the RAM depth
    st(32'h400, $urandom);
    ld(32'h000, 1'b1);
    st(32'h000, $urandom);
    ld(32'h400, 1'b1);
    idle(2);

    // Reset while a load is waiting: no response, read data cleared
    dmem_req  = 1'b1;
    dmem_we   = 1'b0;
    dmem_addr = 32'h40;
    @(negedge clk);
    step(1'b0, 1'b1);
    reset    = 1'b1;
    dmem_req = 1'b0;
    step(1'b0, 1'b0);
    reset    = 1'b0;
    pend     = 0;
    last_rd  = 32'd0;
    rd_known = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ld_rvalid", 32'(dmem_rvalid), 32'd0);
      chk("rst_ld_empty", 32'(wbuf_empty), 32'd1);
      chk("rst_ld_rd", dmem_rd, last_rd);
      step(1'b0, 1'b0);
    end

    // Reset with a posted write still pending: write lost, RAM keeps old value
    old = ref_mem[widx(32'h40)];
    st(32'h40, ~old);
    reset    = 1'b1;
    dmem_req = 1'b0;
    step(1'b0, 1'b0);
    reset = 1'b0;
    pend  = 0;
    ref_mem[widx(32'h40)] = old;
    @(negedge clk);
    chk("rst_wb_empty", 32'(wbuf_empty), 32'd1);
    step(1'b0, 1'b0);
    ld(32'h40, 1'b1);

    // Random traffic over a small aliased window
    for (int n = 0; n < 150; n++) begin
      w = $urandom_range(0, 15);
      a = ($urandom & 32'hFFFF_FC00) | (32'(w) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      case ($urandom_range(0, 2))
        0: st(a, d);
        1: if (written[w]) ld(a, 1'b1); else st(a, d);
        default: idle($urandom_range(1, 2));
      endcase
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
